// File: rtl/sm83_irq_pkg.sv
// Shared constants for the SM83 interrupt controller: register addresses,
// interrupt bit positions and the IF read-back mask.
package sm83_irq_pkg;

    localparam logic [15:0] IF_ADDR_DEF  = 16'hFF0F;
    localparam logic [15:0] IE_ADDR_DEF  = 16'hFFFF;

    localparam int NUM_IRQ = 5;
    localparam int VBLANK  = 0;
    localparam int STAT    = 1;
    localparam int TIMER   = 2;
    localparam int SERIAL  = 3;
    localparam int JOYPAD  = 4;

    // Unimplemented IF bits 7:5 always read back as ones.
    localparam logic [7:0] IF_READ_MASK = 8'hE0;

endpackage

// File: rtl/sm83_edge_det.sv
// Rising-edge detector: registers the input and flags a 0->1 transition
// combinationally in the cycle it is first seen.
module sm83_edge_det (
    input  logic CLK,
    input  logic RESET,
    input  logic in,
    output logic rise
);

    logic q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) q <= 1'b0;
        else       q <= in;
    end

    assign rise = in & ~q;

endmodule

// File: rtl/sm83_irq_ctrl.sv
// SM83 interrupt controller: IF/IE registers on the core bus, source edge
// capture, acknowledge clearing and registered read-back.
module sm83_irq_ctrl
    import sm83_irq_pkg::*;
#(
    parameter logic [15:0] IF_ADDR = IF_ADDR_DEF,
    parameter logic [15:0] IE_ADDR = IE_ADDR_DEF
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] A,
    input  logic [7:0]  D_IN,
    output logic [7:0]  D_OUT,
    output logic        D_OE,
    input  logic        RD,
    input  logic        WR,
    output logic        MMIO_REQ,
    input  logic [4:0]  IRQ_SRC,
    output logic [7:0]  CPU_IRQ_TRIG,
    input  logic [7:0]  CPU_IRQ_ACK
);

    logic [NUM_IRQ-1:0] if_q;
    logic [NUM_IRQ-1:0] if_next;
    logic [NUM_IRQ-1:0] src_rise;
    logic [7:0]         ie_q;
    logic               wr_rise;
    logic               wr_blk;
    logic               wr_en;
    logic               rd_en;
    logic               hit_if;
    logic               hit_ie;
    logic               unused_ack_hi;

    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_src_edge
        sm83_edge_det u_src_edge (
            .CLK   (CLK),
            .RESET (RESET),
            .in    (IRQ_SRC[i]),
            .rise  (src_rise[i])
        );
    end

    sm83_edge_det u_wr_edge (
        .CLK   (CLK),
        .RESET (RESET),
        .in    (WR),
        .rise  (wr_rise)
    );

    assign hit_if        = (A == IF_ADDR);
    assign hit_ie        = (A == IE_ADDR);
    assign MMIO_REQ      = hit_if | hit_ie;
    // A WR already high when reset released must drop before it may write.
    assign wr_en         = wr_rise & ~wr_blk;
    assign rd_en         = RD & ~WR & MMIO_REQ;
    assign CPU_IRQ_TRIG  = {3'b000, if_q & ie_q[NUM_IRQ-1:0]};
    assign unused_ack_hi = ^CPU_IRQ_ACK[7:NUM_IRQ];

    // Per-bit priority: new edge, then CPU write, then acknowledge.
    always_comb begin
        if_next = if_q;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (src_rise[i])          if_next[i] = 1'b1;
            else if (wr_en && hit_if) if_next[i] = D_IN[i];
            else if (CPU_IRQ_ACK[i])  if_next[i] = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            if_q   <= '0;
            ie_q   <= 8'h00;
            wr_blk <= 1'b1;
            D_OUT  <= 8'h00;
            D_OE   <= 1'b0;
        end else begin
            if_q <= if_next;
            if (wr_en && hit_ie) ie_q <= D_IN;
            if (!WR)             wr_blk <= 1'b0;
            if (rd_en) D_OUT <= hit_if ? (IF_READ_MASK | {3'b000, if_q}) : ie_q;
            D_OE <= rd_en;
        end
    end

endmodule

// File: tb/tb_sm83_irq_ctrl.sv
// Self-checking bench for sm83_irq_ctrl: directed scenarios followed by
// randomized traffic, all compared against a behavioural register model.
module tb_sm83_irq_ctrl;

    localparam logic [15:0] IFA = 16'hFF0F;
    localparam logic [15:0] IEA = 16'hFFFF;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [15:0] A;
    logic [7:0]  D_IN;
    logic [7:0]  D_OUT;
    logic        D_OE;
    logic        RD;
    logic        WR;
    logic        MMIO_REQ;
    logic [4:0]  IRQ_SRC;
    logic [7:0]  CPU_IRQ_TRIG;
    logic [7:0]  CPU_IRQ_ACK;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [4:0] m_if;
    logic [7:0] m_ie;
    logic [4:0] m_src;
    logic       m_wr;
    logic       m_blk;
    logic [7:0] m_dout;
    logic       m_oe;

    sm83_irq_ctrl #(.IF_ADDR(IFA), .IE_ADDR(IEA)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .A            (A),
        .D_IN         (D_IN),
        .D_OUT        (D_OUT),
        .D_OE         (D_OE),
        .RD           (RD),
        .WR           (WR),
        .MMIO_REQ     (MMIO_REQ),
        .IRQ_SRC      (IRQ_SRC),
        .CPU_IRQ_TRIG (CPU_IRQ_TRIG),
        .CPU_IRQ_ACK  (CPU_IRQ_ACK)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("comparison %s", tag);
        end
    endtask

    task automatic model_reset();
        m_if = '0; m_ie = '0; m_src = '0; m_wr = 1'b0; m_blk = 1'b1;
        m_dout = 8'h00; m_oe = 1'b0;
    endtask

    // One rising edge of the model, using the inputs present at that edge.
    task automatic model_edge();
        logic [4:0] rise;
        logic       wr_now;
        rise   = IRQ_SRC & ~m_src;
        wr_now = WR && !m_wr && !m_blk;
        if (RD && !WR && (A == IFA || A == IEA)) begin
            m_oe   = 1'b1;
            m_dout = (A == IFA) ? (8'hE0 | {3'b000, m_if}) : m_ie;
        end else begin
            m_oe = 1'b0;
        end
        if (wr_now && A == IEA) m_ie = D_IN;
        m_if  = ((wr_now && A == IFA) ? D_IN[4:0] : (m_if & ~CPU_IRQ_ACK[4:0])) | rise;
        m_src = IRQ_SRC;
        m_wr  = WR;
        if (!WR) m_blk = 1'b0;
    endtask

    task automatic cycle();
        @(posedge CLK);
        model_edge();
        #1;
        chk("trig", CPU_IRQ_TRIG, {3'b000, m_if & m_ie[4:0]});
        chk("d_oe", {7'b0, D_OE}, {7'b0, m_oe});
        chk("d_out", D_OUT, m_dout);
        chk("mmio", {7'b0, MMIO_REQ}, {7'b0, (A == IFA) || (A == IEA)});
    endtask

    task automatic wr_reg(input logic [15:0] addr, input logic [7:0] data);
        A = addr; D_IN = data; WR = 1'b1; RD = 1'b0;
        cycle();
        WR = 1'b0;
        cycle();
    endtask

    initial begin
        RESET = 1'b1; A = 16'h0000; D_IN = 8'h00; RD = 1'b0; WR = 1'b0;
        IRQ_SRC = 5'h00; CPU_IRQ_ACK = 8'h00;
        model_reset();
        #2;
        chk("rst_trig", CPU_IRQ_TRIG, 8'h00);
        chk("rst_oe", {7'b0, D_OE}, 8'h00);
        chk("rst_dout", D_OUT, 8'h00);
        #10 RESET = 1'b0;
        cycle();

        // Timer request enabled, then acknowledged
        wr_reg(IEA, 8'h05);
        IRQ_SRC = 5'h04;
        cycle();
        chk("timer_trig", CPU_IRQ_TRIG, 8'h04);
        IRQ_SRC = 5'h00; CPU_IRQ_ACK = 8'h04;
        cycle();
        CPU_IRQ_ACK = 8'h00;
        chk("timer_ack", CPU_IRQ_TRIG, 8'h00);

        // Edge and acknowledge in the same cycle: edge wins
        wr_reg(IEA, 8'hFF);
        IRQ_SRC = 5'h01; CPU_IRQ_ACK = 8'h01;
        cycle();
        chk("edge_vs_ack", CPU_IRQ_TRIG, 8'h01);
        IRQ_SRC = 5'h00; CPU_IRQ_ACK = 8'h00;
        wr_reg(IFA, 8'h00);

        // WR held four cycles writes once
        A = IFA; D_IN = 8'hFF; WR = 1'b1;
        cycle();
        chk("hold_c1", CPU_IRQ_TRIG, 8'h1F);
        CPU_IRQ_ACK = 8'h02;
        cycle();
        chk("hold_c2", CPU_IRQ_TRIG, 8'h1D);
        CPU_IRQ_ACK = 8'h00; IRQ_SRC = 5'h02;
        cycle();
        chk("hold_c3", CPU_IRQ_TRIG, 8'h1F);
        CPU_IRQ_ACK = 8'h01;
        cycle();
        chk("hold_c4", CPU_IRQ_TRIG, 8'h1E);
        WR = 1'b0; CPU_IRQ_ACK = 8'h00; IRQ_SRC = 5'h00;
        cycle();

        // Read-back of IF and IE
        wr_reg(IFA, 8'h03);
        A = IFA; RD = 1'b1;
        cycle();
        chk("rd_if_oe", {7'b0, D_OE}, 8'h01);
        chk("rd_if", D_OUT, 8'hE3);
        RD = 1'b0;
        wr_reg(IEA, 8'hA5);
        A = IEA; RD = 1'b1;
        cycle();
        chk("rd_ie", D_OUT, 8'hA5);
        RD = 1'b0;
        cycle();
        chk("rd_off_oe", {7'b0, D_OE}, 8'h00);
        chk("rd_hold", D_OUT, 8'hA5);

        // Address decode boundaries
        A = 16'hFF0E; RD = 1'b1;
        #1 chk("mmio_ff0e", {7'b0, MMIO_REQ}, 8'h00);
        cycle();
        chk("oe_ff0e", {7'b0, D_OE}, 8'h00);
        A = 16'hFF10;
        #1 chk("mmio_ff10", {7'b0, MMIO_REQ}, 8'h00);
        cycle();
        chk("oe_ff10", {7'b0, D_OE}, 8'h00);
        RD = 1'b0; A = 16'hFFFF;
        #1 chk("mmio_ffff", {7'b0, MMIO_REQ}, 8'h01);
        cycle();

        // Mid-cycle reset with a held source and a held WR
        wr_reg(IEA, 8'hFF);
        wr_reg(IFA, 8'h1F);
        chk("pre_rst", CPU_IRQ_TRIG, 8'h1F);
        IRQ_SRC = 5'h10; A = IFA; D_IN = 8'hFF; WR = 1'b1;
        RESET = 1'b1;
        model_reset();
        #1;
        chk("mid_rst_trig", CPU_IRQ_TRIG, 8'h00);
        chk("mid_rst_oe", {7'b0, D_OE}, 8'h00);
        #9 RESET = 1'b0;
        cycle();
        WR = 1'b0; RD = 1'b1;
        cycle();
        chk("rel_if", D_OUT, 8'hF0);
        RD = 1'b0;
        wr_reg(IFA, 8'h01);
        RD = 1'b1;
        cycle();
        chk("rewrite_if", D_OUT, 8'hE1);
        RD = 1'b0;
        wr_reg(IEA, 8'hFF);

        // Randomized traffic against the model
        for (int n = 0; n < 500; n++) begin
            case ($urandom_range(0, 4))
                0, 1:    A = IFA;
                2:       A = IEA;
                3:       A = ($urandom_range(0, 1) != 0) ? 16'hFF0E : 16'hFF10;
                default: A = 16'($urandom);
            endcase
            D_IN = 8'($urandom);
            RD   = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 2) == 0) WR = ~WR;
            IRQ_SRC = IRQ_SRC ^ (5'($urandom) & 5'($urandom));
            case ($urandom_range(0, 3))
                0:       CPU_IRQ_ACK = 8'h01 << $urandom_range(0, 7);
                1:       CPU_IRQ_ACK = 8'($urandom);
                default: CPU_IRQ_ACK = 8'h00;
            endcase
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sm83_irq_ctrl.md
SM83_IRQ_CTRL -- requirements
Module: sm83_irq_ctrl

Interface
REQ-001 SHALL have parameter IF_ADDR, default 16'hFF0F, giving the address of the interrupt flag register.
REQ-002 SHALL have parameter IE_ADDR, default 16'hFFFF, giving the address of the interrupt enable register.
REQ-003 SHALL have port CLK, input, 1 bit; the single clock, and all state updates occur on its rising edge.
REQ-004 SHALL have port RESET, input, 1 bit; asynchronous, active-high reset.
REQ-005 SHALL have port A, input, 16 bits; the core address bus.
REQ-006 SHALL have port D_IN, input, 8 bits; core write data.
REQ-007 SHALL have port D_OUT, output, 8 bits; read data returned to the core.
REQ-008 SHALL have port D_OE, output, 1 bit; high while D_OUT is driving valid data.
REQ-009 SHALL have port RD, input, 1 bit; core read strobe, active-high.
REQ-010 SHALL have port WR, input, 1 bit; core write strobe, active-high.
REQ-011 SHALL have port MMIO_REQ, output, 1 bit; the register-hit indication returned to the core.
REQ-012 SHALL have port IRQ_SRC, input, 5 bits; peripheral requests: bit 0 VBlank, 1 STAT, 2 Timer, 3 Serial, 4 Joypad.
REQ-013 SHALL have port CPU_IRQ_TRIG, output, 8 bits; pending and enabled interrupts presented to the core.
REQ-014 SHALL have port CPU_IRQ_ACK, input, 8 bits; one-hot acknowledge from the core.

Function
REQ-015 SHALL hold state IF[4:0], IE[7:0], src_q[4:0] and wr_q.
REQ-016 SHALL drive MMIO_REQ combinationally high when A equals IF_ADDR or IE_ADDR, regardless of RD/WR.
REQ-017 SHALL set IF[n] on each 0->1 transition of IRQ_SRC[n], i.e. IRQ_SRC[n] & ~src_q[n]; src_q SHALL register IRQ_SRC every cycle.
REQ-018 SHALL clear IF[n] in the cycle CPU_IRQ_ACK[n] is high, for n in 0..4; ACK bits 7:5 SHALL be ignored.
REQ-019 SHALL perform a write only on the first cycle of a WR pulse (WR & ~wr_q), so a WR held high for several cycles writes exactly once.
REQ-020 SHALL, on a write to IF_ADDR, load IF from D_IN[4:0] and discard D_IN[7:5].
REQ-021 SHALL, on a write to IE_ADDR, load all 8 bits of IE.
REQ-022 SHALL resolve same-cycle events per IF bit with priority, highest first: rising source edge, CPU write, ACK clear. A new edge is never lost.
REQ-023 SHALL drive CPU_IRQ_TRIG = {3'b000, IF & IE[4:0]} combinationally from registered state, so it changes one cycle after the IF/IE update.
REQ-024 SHALL register read data: in a cycle where RD=1 and A hits, the next rising edge SHALL load D_OUT and set D_OE.
REQ-025 SHALL load D_OUT as {3'b111, IF} for IF_ADDR and as IE for IE_ADDR.
REQ-026 SHALL return the value held in the cycle before a same-cycle update when a read and an update coincide (no bypass).
REQ-027 SHALL clear D_OE on the edge after RD falls or A misses; D_OUT SHALL hold its last value while D_OE is low.
REQ-028 SHALL ignore a cycle where RD and WR are both high for reads; the write still occurs.

Reset
REQ-029 SHALL, while RESET is high, force IF=0, IE=0, src_q=0, wr_q=0, D_OUT=8'h00 and D_OE=0 immediately, independent of CLK.
REQ-030 SHALL keep CPU_IRQ_TRIG at 8'h00 during reset as a consequence of REQ-029.
REQ-031 SHALL register a source held high at reset release as one rising edge on the first clock after release.
REQ-032 SHALL, if RESET is asserted during a WR pulse, not perform that write after release unless WR falls and rises again.

Structure
REQ-033 SHALL place in package sm83_irq_pkg: the default addresses, the interrupt bit-index constants (VBLANK=0 .. JOYPAD=4), and the IF read-mask constant 8'hE0.
REQ-034 SHALL implement the edge detector as a single sub-module sm83_edge_det (CLK, RESET, in, rise), instantiated 5 times for IRQ_SRC and once for WR.

Verification
REQ-035 SHALL cover: IE=8'h05, pulse IRQ_SRC[2] -> IF=5'h04, TRIG=8'h04 one cycle later; ACK=8'h04 -> TRIG=8'h00 next cycle.
REQ-036 SHALL cover: IRQ_SRC[0] rises in the same cycle as ACK[0] -> IF[0] stays 1.
REQ-037 SHALL cover: WR held 4 cycles writing IF with D_IN=8'hFF while IRQ_SRC[1] rises on cycle 3 -> IF=5'h1F, exactly one write.
REQ-038 SHALL cover: IF=5'h03, read IF_ADDR -> D_OE high one cycle after RD, D_OUT=8'hE3; read IE_ADDR after IE<=8'hA5 -> D_OUT=8'hA5.
REQ-039 SHALL cover: A=16'hFF0E and A=16'hFF10 -> MMIO_REQ=0, D_OE=0; A=16'hFFFF -> MMIO_REQ=1.
REQ-040 SHALL cover: RESET asserted mid-cycle with IF=5'h1F -> IF=0 and TRIG=0 before the next CLK edge; IRQ_SRC[4] held high through release -> IF=5'h10 one cycle after release.
